// File: rtl/aes_pkg.sv
// AES shared types and S-box tables for the decipher datapath.
// Provides INV_SBOX, SBOX, state/byte typedefs and the InvSubBytes FSM enum.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_BUSY = 2'd1,
    SB_DONE = 2'd2
  } inv_sb_state_t;

  // Index 0 is the leftmost byte of each concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// Valid/ready bundle around the InvSubBytes stage.
// Ports: in_valid/in_ready/State_in, out_valid/out_ready/State_out, busy.
interface inv_sub_bytes_seq_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_state_t State_in;
  logic       out_valid;
  logic       out_ready;
  aes_state_t State_out;
  logic       busy;

  modport master (
    output in_valid, State_in, out_ready,
    input  in_ready, out_valid, State_out, busy
  );

  modport slave (
    input  in_valid, State_in, out_ready,
    output in_ready, out_valid, State_out, busy
  );

endinterface

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup.
// Ports: din (8-bit byte in), dout (8-bit substituted byte out).
module inv_sbox
  import aes_pkg::*;
(
  input  aes_byte_t din,
  output aes_byte_t dout
);

  assign dout = INV_SBOX[din];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Time-multiplexed InvSubBytes: BYTES_PER_CYCLE lookups per clock.
// Ports: clk, rst_n, bus (slave); chk_err when INV_SUB_BYTES_CHECK_EN.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
)(
  input  logic clk,
  input  logic rst_n,
  inv_sub_bytes_seq_if.slave bus
`ifdef INV_SUB_BYTES_CHECK_EN
  ,
  output logic chk_err
`endif
);

  localparam int N  = 16 / BYTES_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int W  = 8 * BYTES_PER_CYCLE;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = SB_IDLE;
  localparam logic [1:0] S_BUSY = SB_BUSY;
  localparam logic [1:0] S_DONE = SB_DONE;

  logic [1:0]    st;
  aes_state_t    state_q;
  logic [CW-1:0] cnt;
  logic [W-1:0]  chunk_in;
  logic [W-1:0]  chunk_out;

  assign chunk_in = state_q[int'(cnt)*W +: W];

  for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_lane
    inv_sbox u_sbox (
      .din  (chunk_in[8*i +: 8]),
      .dout (chunk_out[8*i +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      state_q <= '0;
      cnt     <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (bus.in_valid) begin
            state_q <= bus.State_in;
            cnt     <= '0;
            st      <= S_BUSY;
          end
        end
        S_BUSY: begin
          state_q[int'(cnt)*W +: W] <= chunk_out;
          if (cnt == LAST) begin
            st <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            st <= S_IDLE;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (st == S_IDLE);
  assign bus.out_valid = (st == S_DONE);
  assign bus.busy      = (st != S_IDLE);
  assign bus.State_out = state_q;

`ifdef INV_SUB_BYTES_CHECK_EN
  // Re-encrypt each processed chunk; any disagreement is a lookup fault.
  logic [W-1:0] chunk_re;

  for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_chk
    assign chunk_re[8*i +: 8] = SBOX[chunk_out[8*i +: 8]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (st == S_BUSY && chunk_re != chunk_in) begin
      chk_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq across BYTES_PER_CYCLE.
// Directed vector table plus reset, backpressure and sweep sequences.
module tb_inv_sub_bytes_seq;
  import aes_pkg::*;

  localparam int NI = 5;
  localparam int M  = 2;
  localparam int BPC [NI] = '{1, 2, 4, 8, 16};

  typedef struct {
    aes_state_t din;
    aes_state_t exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  aes_state_t    state_in;
  logic [NI-1:0] ordy;
  logic [NI-1:0] irdy;
  logic [NI-1:0] ov;
  logic [NI-1:0] bz;
  aes_state_t    so [NI];
`ifdef INV_SUB_BYTES_CHECK_EN
  logic [NI-1:0] ce;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    inv_sub_bytes_seq_if u_if ();
    assign u_if.in_valid  = in_valid;
    assign u_if.State_in  = state_in;
    assign u_if.out_ready = ordy[g];
    assign irdy[g] = u_if.in_ready;
    assign ov[g]   = u_if.out_valid;
    assign bz[g]   = u_if.busy;
    assign so[g]   = u_if.State_out;

    inv_sub_bytes_seq #(
      .BYTES_PER_CYCLE(BPC[g])
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (u_if.slave)
`ifdef INV_SUB_BYTES_CHECK_EN
      ,
      .chk_err (ce[g])
`endif
    );
  end

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept din on one edge, then count edges until out_valid.
  task automatic run_txn(input aes_state_t din,
                         input int idx,
                         output int lat,
                         output aes_state_t dout);
    state_in = din;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    state_in = ~din;
    lat = 0;
    while (!ov[idx] && lat < 40) begin
      tick();
      lat++;
    end
    dout = so[idx];
  endtask

  localparam aes_state_t C1_IN  = 128'h7a9f102789d5f50b2beffd9f3dca4ce7;
  localparam aes_state_t C1_OUT = 128'hbd6e7c3df2b5779e0b61216e8b105db0;

  vec_t       vt [5];
  int         lat;
  aes_state_t res;
  int         bad;
  int         slat [NI];
  aes_state_t sres [NI];
  int         exp_lat [NI] = '{16, 8, 4, 2, 1};

  initial begin
    vt[0] = '{C1_IN, C1_OUT};
    vt[1] = '{128'h7a9f102789d5f50b2beffd9f3dca4ea7,
              128'hbd6e7c3df2b5779e0b61216e8b10b689};
    vt[2] = '{{16{8'h63}}, {16{8'h00}}};
    vt[3] = '{{16{8'h16}}, {16{8'hff}}};
    vt[4] = '{{{15{8'h7c}}, 8'hed}, {{15{8'h01}}, 8'h53}};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    state_in = '0;
    ordy     = '1;
    #1;
    chk("rst_in_ready", 128'(irdy[M]), 128'd1);
    chk("rst_out_valid", 128'(ov[M]), 128'd0);
    chk("rst_busy", 128'(bz[M]), 128'd0);
    chk("rst_state_out", so[M], 128'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      chk($sformatf("v%0d_in_ready", i), 128'(irdy[M]), 128'd1);
      run_txn(vt[i].din, M, lat, res);
      chk($sformatf("v%0d_data", i), res, vt[i].exp);
      chk($sformatf("v%0d_latency", i), 128'(lat), 128'd4);
      chk($sformatf("v%0d_busy_done", i), 128'(bz[M]), 128'd1);
      tick();
      chk($sformatf("v%0d_ov_drop", i), 128'(ov[M]), 128'd0);
    end

`ifdef INV_SUB_BYTES_CHECK_EN
    chk("chk_err_clean", 128'(ce[M]), 128'd0);
`endif

    // Backpressure in DONE with a competing input offered.
    repeat (20) tick();
    ordy[M] = 1'b0;
    run_txn({16{8'h63}}, M, lat, res);
    chk("bp_data", res, {16{8'h00}});
    chk("bp_latency", 128'(lat), 128'd4);
    in_valid = 1'b1;
    state_in = {16{8'h16}};
    bad = 0;
    repeat (10) begin
      tick();
      if (so[M] !== {16{8'h00}} || irdy[M] !== 1'b0 || ov[M] !== 1'b1)
        bad++;
    end
    chk("bp_hold_bad_cycles", 128'(bad), 128'd0);
    in_valid = 1'b0;
    ordy[M]  = 1'b1;
    tick();
    chk("bp_release_ov", 128'(ov[M]), 128'd0);
    chk("bp_release_idle", 128'(irdy[M]), 128'd1);
    run_txn({16{8'h16}}, M, lat, res);
    chk("bp_next_data", res, {16{8'hff}});
    chk("bp_next_latency", 128'(lat), 128'd4);
    tick();

    // Reset two cycles into BUSY.
    repeat (20) tick();
    state_in = C1_IN;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_busy_before", 128'(bz[M]), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 128'(irdy[M]), 128'd1);
    chk("mid_rst_out_valid", 128'(ov[M]), 128'd0);
    chk("mid_rst_state_out", so[M], 128'h0);
    tick();
    tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (ov[M] !== 1'b0) bad++;
    end
    chk("mid_rst_no_output", 128'(bad), 128'd0);

    // Parameter sweep: all instances start together from IDLE.
    for (int g = 0; g < NI; g++) begin
      slat[g] = -1;
      sres[g] = '0;
    end
    state_in = C1_IN;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    state_in = '0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      for (int g = 0; g < NI; g++) begin
        if (ov[g] && slat[g] < 0) begin
          slat[g] = k;
          sres[g] = so[g];
        end
      end
    end
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("sweep_b%0d_data", BPC[g]), sres[g], C1_OUT);
      chk($sformatf("sweep_b%0d_latency", BPC[g]),
          128'(slat[g]), 128'(exp_lat[g]));
    end

`ifdef INV_SUB_BYTES_CHECK_EN
    repeat (5) tick();
    force g_dut[2].u_dut.g_lane[0].u_sbox.dout = 8'h01;
    run_txn({16{8'h63}}, M, lat, res);
    release g_dut[2].u_dut.g_lane[0].u_sbox.dout;
    tick();
    chk("chk_err_set", 128'(ce[M]), 128'd1);
    run_txn({16{8'h16}}, M, lat, res);
    tick();
    chk("chk_err_sticky", 128'(ce[M]), 128'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
